// File: rtl/vend_pkg.sv
// Shared widths, discount defaults and value types for the vending checkout path.
package vend_pkg;

  localparam int unsigned PRICE_W = 8;
  localparam int unsigned QTY_W   = 4;
  localparam int unsigned AMT_W   = 16;

  localparam int unsigned DISC_THRESHOLD = 10;
  localparam int unsigned DISC_PERCENT   = 10;

  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [QTY_W-1:0]   qty_t;
  typedef logic [AMT_W-1:0]   amt_t;

endpackage

// File: rtl/vend_checkout_calc_if.sv
// Product/price/payment inputs and checkout results between the front panel and the calculator.
interface vend_checkout_calc_if;
  import vend_pkg::*;

  logic [2:0] product_id;
  price_t     price0;
  price_t     price1;
  price_t     price2;
  price_t     price3;
  price_t     price4;
  price_t     price5;
  price_t     price6;
  price_t     price7;
  qty_t       quantity;
  amt_t       amount_paid;

  price_t     price;
  amt_t       total_price;
  logic       discount;
  amt_t       discounted_price;
  amt_t       remaining_amount;
  logic       insufficient;

  modport master (
    output product_id, price0, price1, price2, price3, price4, price5, price6, price7,
    output quantity, amount_paid,
    input  price, total_price, discount, discounted_price, remaining_amount, insufficient
  );

  modport slave (
    input  product_id, price0, price1, price2, price3, price4, price5, price6, price7,
    input  quantity, amount_paid,
    output price, total_price, discount, discounted_price, remaining_amount, insufficient
  );

endinterface

// File: rtl/vend_discount_unit.sv
// Combinational bulk-discount stage: threshold compare plus percentage cut off the total.
module vend_discount_unit
  import vend_pkg::*;
#(
  parameter int unsigned DISC_THRESHOLD = vend_pkg::DISC_THRESHOLD,
  parameter int unsigned DISC_PERCENT   = vend_pkg::DISC_PERCENT
) (
  input  qty_t quantity,
  input  amt_t total,
  output logic discount,
  output amt_t discounted
);

  // total * 100 needs 7 bits of headroom above AMT_W
  localparam int unsigned ProdW = AMT_W + 7;

  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] cut;

  always_comb begin
    discount   = 32'(quantity) >= DISC_THRESHOLD;
    prod       = ProdW'(total) * ProdW'(DISC_PERCENT);
    cut        = prod / ProdW'(100);
    discounted = discount ? AMT_W'(ProdW'(total) - cut) : total;
  end

endmodule

// File: rtl/vend_checkout_calc.sv
// Checkout calculator: price select, multiply, bulk discount and change, all registered once.
module vend_checkout_calc
  import vend_pkg::*;
#(
  parameter int unsigned DISC_THRESHOLD = vend_pkg::DISC_THRESHOLD,
  parameter int unsigned DISC_PERCENT   = vend_pkg::DISC_PERCENT
) (
  input logic            clk,
  input logic            reset,
  vend_checkout_calc_if.slave bus
);

  price_t price_d;
  amt_t   total_d;
  logic   discount_d;
  amt_t   discounted_d;
  amt_t   remaining_d;
  logic   insufficient_d;

  always_comb begin
    price_d = '0;
    unique case (bus.product_id)
      3'd0: price_d = bus.price0;
      3'd1: price_d = bus.price1;
      3'd2: price_d = bus.price2;
      3'd3: price_d = bus.price3;
      3'd4: price_d = bus.price4;
      3'd5: price_d = bus.price5;
      3'd6: price_d = bus.price6;
      3'd7: price_d = bus.price7;
      default: price_d = '0;
    endcase
    total_d = AMT_W'(price_d) * AMT_W'(bus.quantity);
  end

  vend_discount_unit #(
    .DISC_THRESHOLD (DISC_THRESHOLD),
    .DISC_PERCENT   (DISC_PERCENT)
  ) u_discount (
    .quantity   (bus.quantity),
    .total      (total_d),
    .discount   (discount_d),
    .discounted (discounted_d)
  );

  always_comb begin
    insufficient_d = bus.amount_paid < discounted_d;
    remaining_d    = insufficient_d ? '0 : bus.amount_paid - discounted_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.price            <= '0;
      bus.total_price      <= '0;
      bus.discount         <= 1'b0;
      bus.discounted_price <= '0;
      bus.remaining_amount <= '0;
      bus.insufficient     <= 1'b0;
    end else begin
      bus.price            <= price_d;
      bus.total_price      <= total_d;
      bus.discount         <= discount_d;
      bus.discounted_price <= discounted_d;
      bus.remaining_amount <= remaining_d;
      bus.insufficient     <= insufficient_d;
    end
  end

endmodule

// File: tb/tb_vend_checkout_calc.sv
// Self-checking bench for vend_checkout_calc against an arithmetic reference model.
module tb_vend_checkout_calc;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int unsigned prices [8];

  vend_checkout_calc_if bus ();

  vend_checkout_calc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Result vector: {price, total, discount, discounted, remaining, insufficient}
  function automatic logic [57:0] model(input int unsigned p, input int unsigned q,
                                        input int unsigned paid);
    int unsigned total, dp, rem;
    bit d, ins;
    total = p * q;
    d     = q >= 10;
    dp    = d ? total - (total * 10) / 100 : total;
    ins   = paid < dp;
    rem   = ins ? 0 : paid - dp;
    return {p[7:0], total[15:0], d, dp[15:0], rem[15:0], ins};
  endfunction

  function automatic logic [57:0] observed();
    return {bus.price, bus.total_price, bus.discount, bus.discounted_price,
            bus.remaining_amount, bus.insufficient};
  endfunction

  task automatic load_prices();
    bus.price0 = prices[0][7:0]; bus.price1 = prices[1][7:0];
    bus.price2 = prices[2][7:0]; bus.price3 = prices[3][7:0];
    bus.price4 = prices[4][7:0]; bus.price5 = prices[5][7:0];
    bus.price6 = prices[6][7:0]; bus.price7 = prices[7][7:0];
  endtask

  task automatic apply(input int unsigned id, input int unsigned q, input int unsigned paid);
    bus.product_id  = id[2:0];
    bus.quantity    = q[3:0];
    bus.amount_paid = paid[15:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [57:0] exp;
    for (int i = 0; i < 8; i++) prices[i] = 10 * (i + 1);
    load_prices();
    reset = 1'b1;
    apply(5, 14, 999);
    checks++;
    if (observed() !== 58'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", observed(), 58'd0);
    end
    reset = 1'b0;
    apply(0, 0, 0);
    exp = model(10, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL first_after_reset: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_directed();
    int unsigned ids [4]  = '{1, 2, 3, 4};
    int unsigned qtys [4] = '{5, 10, 12, 15};
    int unsigned pays [4] = '{250, 350, 450, 550};
    logic [57:0] hand [4] = '{
      {8'd20, 16'd100, 1'b0, 16'd100, 16'd150, 1'b0},
      {8'd30, 16'd300, 1'b1, 16'd270, 16'd80,  1'b0},
      {8'd40, 16'd480, 1'b1, 16'd432, 16'd18,  1'b0},
      {8'd50, 16'd750, 1'b1, 16'd675, 16'd0,   1'b1}};
    for (int i = 0; i < 4; i++) begin
      apply(ids[i], qtys[i], pays[i]);
      checks++;
      if (observed() !== hand[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %h expected %h", i, observed(), hand[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [57:0] exp;
    apply(6, 9, 700);
    exp = {8'd70, 16'd630, 1'b0, 16'd630, 16'd70, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL below_threshold: got %h expected %h", observed(), exp);
    end
    apply(6, 10, 630);
    exp = {8'd70, 16'd700, 1'b1, 16'd630, 16'd0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL threshold_exact_pay: got %h expected %h", observed(), exp);
    end
    apply(7, 0, 1234);
    exp = {8'd80, 16'd0, 1'b0, 16'd0, 16'd1234, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL zero_qty: got %h expected %h", observed(), exp);
    end
    apply(4, 15, 674);
    exp = {8'd50, 16'd750, 1'b1, 16'd675, 16'd0, 1'b1};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL short_by_one: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_reset_midstream();
    logic [57:0] exp;
    apply(2, 10, 350);
    reset = 1'b1;
    apply(3, 12, 450);
    checks++;
    if (observed() !== 58'd0) begin
      errors++;
      $display("FAIL midstream_reset: got %h expected %h", observed(), 58'd0);
    end
    reset = 1'b0;
    apply(3, 12, 450);
    exp = {8'd40, 16'd480, 1'b1, 16'd432, 16'd18, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL resume_after_reset: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned id, q, paid;
    logic [57:0] exp;
    for (int n = 0; n < 300; n++) begin
      if (n % 50 == 0) begin
        for (int i = 0; i < 8; i++) prices[i] = $urandom_range(0, 255);
        prices[$urandom_range(0, 7)] = 255;
        load_prices();
      end
      id   = $urandom_range(0, 7);
      q    = $urandom_range(0, 15);
      paid = (n % 3 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4000);
      apply(id, q, paid);
      exp = model(prices[id], q, paid);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random_%0d id=%0d q=%0d paid=%0d: got %h expected %h",
                 n, id, q, paid, observed(), exp);
      end
    end
  endtask

  initial begin
    bus.product_id  = '0;
    bus.quantity    = '0;
    bus.amount_paid = '0;
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
